hamming_secded_pipe: RTL
========================

# hamming_secded_pipe

Parametrised Hamming SECDED codec that encodes or decodes per transaction, in a 2-stage pipeline with valid/ready handshakes on input and output. It generalises the fixed 8-bit Hamming(12,8) encoder to any data width. It adds an overall-parity bit, single-error correction, double-error detection, and saturating error statistics. It sits between a data producer and a storage or link path, so one instance serves both the write path (encode) and the read path (decode).

## Interface
- DATA_W, 8: data bits per word, ≥ 4.
- PAR_W, derived: smallest r with 2^r ≥ DATA_W + r + 1 (4 for DATA_W = 8).
- CW_W, derived: DATA_W + PAR_W + 1 (13 for DATA_W = 8).
- CNT_W, 16: width of each error counter.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  pipeline accepts this cycle.
- in_mode  in  1  0 = encode, 1 = decode.
- in_data  in  CW_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts this cycle.
- out_mode  out  1  mode of the word being presented.
- out_data  out  CW_W  encoded codeword, or corrected codeword in decode.
- out_syndrome  out  PAR_W  decode syndrome; 0 in encode.
- out_single_err  out  1  decode: single error corrected.
- out_double_err  out  1  decode: uncorrectable error detected.
- clear_counts  in  1  synchronous clear of both counters.
- corr_count  out  CNT_W  saturating count of single errors delivered.
- uncorr_count  out  CNT_W  saturating count of double errors delivered.

## Operation
- **Codeword layout:** {P, p[PAR_W-1:0], d[DATA_W-1:0]}, with P at the MSB.
- **Hamming positions:** positions run from 1 upward. Data bit k occupies the (k+1)-th position that is not a power of two, so d0→3, d1→5, d2→6, d3→7, d4→9, and so on. Parity bit p[i] sits at position 2^i.
- **Parity bits:** p[i] = XOR of every data bit whose position has bit i set. For DATA_W = 8:
  - p0 = d0^d1^d3^d4^d6
  - p1 = d0^d2^d3^d5^d6
  - p2 = d1^d2^d3^d7
  - p3 = d4^d5^d6^d7
- **Overall parity:** P = XOR of all d and all p bits, so the full codeword has even parity.
- **Encode:** out_data = the codeword. out_syndrome = 0 and both error flags = 0.
- **Decode:**
  - syndrome = recomputed p XOR received p.
  - ov = XOR of all CW_W received bits.
- **Decode classification:**
  - syndrome 0, ov 0: clean. Data passes through unchanged.
  - ov 1, syndrome 0: P bit is in error. Correct P; single_err = 1.
  - ov 1, syndrome maps to a valid position (≤ DATA_W + PAR_W): flip that data or parity bit; single_err = 1.
  - ov 1, syndrome > DATA_W + PAR_W: double_err = 1; out_data = received word unchanged.
  - ov 0, syndrome ≠ 0: double_err = 1; out_data = received word unchanged.
  - single_err and double_err are never both 1.
- **Error counters:**
  - They update only on an output handshake (out_valid & out_ready) in decode mode.
  - corr_count increments on single_err; uncorr_count increments on double_err.
  - Both saturate at all-ones and never wrap.
  - clear_counts zeroes both counters and wins over a simultaneous increment.

## Timing
- **Pipeline:** two register stages.
  - S1 registers mode, the received or assembled word, syndrome and ov.
  - S2 registers the corrected result and the flags, and drives all out_* signals.
- **Advance condition:** adv = !out_valid | out_ready. in_ready = adv, purely combinational from out_valid and out_ready. Both stages move together when adv = 1; bubbles are not collapsed.
- **Acceptance:** a word is accepted when in_valid & in_ready.
- **Latency:** out_valid rises 2 cycles after acceptance when out_ready is held high. Throughput is 1 word per cycle.
- **Stall:** when out_valid & !out_ready, S1 and S2 hold, and out_data, out_mode, out_syndrome and the flags stay stable.
- **Mode mixing:** modes may change every transaction. Each word carries its own mode through both stages.
- **Reset:** on the clock edge with rst = 1, all stage valids, out_valid, out_data, out_mode, out_syndrome, both flags and both counters go to 0. Any words in flight are discarded. in_ready is 1 in the cycle after reset.
- **Counter visibility:** counters change on the edge that completes the handshake and are visible in the next cycle.

## Test plan
- **Encode (DATA_W = 8):** inputs 0x01, 0xAA, 0xFF back-to-back with out_ready = 1.
  - Required out_data: 13'h1301, 13'h14AA, 13'h03FF, on consecutive cycles starting 2 cycles after the first accept.
  - Flags and syndrome are 0.
- **Single-bit corrections:**
  - Decode 0x1300 (d0 flipped) → out_data 0x1301, syndrome 3, single_err = 1.
  - Decode 0x0301 (P flipped) → out_data 0x1301, syndrome 0, single_err = 1.
  - Decode 0x1B01 (p3 flipped) → out_data 0x1301, syndrome 8.
- **Double error:** decode 0x1302 (d0 and d1 flipped) → double_err = 1, syndrome 6, out_data 0x1302; uncorr_count increments by 1.
- **Exhaustive:** all 256 data values encoded, then decoded clean, then each of the 13 single-bit flips and a sample of double flips decoded.
  - Every single-bit flip returns the original codeword.
  - Every double flip asserts double_err.
- **Backpressure:** send 3 words, hold out_ready = 0 for 4 cycles, then release.
  - in_ready = 0 while out_valid & !out_ready.
  - out_data stays stable during the stall.
  - All 3 words are delivered in order with none lost or duplicated.
- **Counters and reset:** with CNT_W = 2, deliver 5 single errors → corr_count = 3 (saturated).
  - clear_counts asserted in the same cycle as a single-error handshake → corr_count = 0.
  - rst asserted with 2 words in flight → out_valid = 0 the next cycle, and nothing is emitted afterwards.

Source files
------------

// File: rtl/hamming_secded_pipe_if.sv
// rtl/hamming_secded_pipe_if.sv - input/output stream bundle of the SECDED codec pipeline
interface hamming_secded_pipe_if #(
  parameter int DATA_W = 8
);
  // Smallest r with 2^r >= DATA_W + r + 1
  function automatic int calc_par_w(int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int PAR_W = calc_par_w(DATA_W);
  localparam int CW_W  = DATA_W + PAR_W + 1;

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [CW_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [CW_W-1:0]  out_data;
  logic [PAR_W-1:0] out_syndrome;
  logic             out_single_err;
  logic             out_double_err;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data, out_syndrome,
           out_single_err, out_double_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data, out_syndrome,
           out_single_err, out_double_err
  );
endinterface

// File: rtl/hamming_secded_pipe.sv
// rtl/hamming_secded_pipe.sv - two-stage Hamming SECDED encode/decode pipeline with error counters
module hamming_secded_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_secded_pipe_if.slave bus,
  input  logic                 clear_counts,
  output logic [CNT_W-1:0]     corr_count,
  output logic [CNT_W-1:0]     uncorr_count
);

  function automatic int calc_par_w(int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int PAR_W   = calc_par_w(DATA_W);
  localparam int CW_W    = DATA_W + PAR_W + 1;
  localparam int MAX_POS = DATA_W + PAR_W;

  // Hamming position of data bit k: the (k+1)-th position that is not a power of two
  function automatic int data_pos(int k);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < k) begin
      pos++;
      if ((pos & (pos - 1)) != 0) cnt++;
    end
    return pos;
  endfunction

  // Parity bit i covers every data bit whose position has bit i set
  function automatic logic [PAR_W-1:0] calc_par(logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < PAR_W; i++) begin
      for (int k = 0; k < DATA_W; k++) begin
        if (((data_pos(k) >> i) & 1) == 1) p[i] = p[i] ^ d[k];
      end
    end
    return p;
  endfunction

  // Both stages move together; a stalled output freezes the whole pipe
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  logic [DATA_W-1:0] in_d;
  logic [PAR_W-1:0]  in_par;
  logic [CW_W-1:0]   s1_word_d;
  logic [PAR_W-1:0]  s1_syn_d;
  logic              s1_ov_d;

  // Stage 1 front end: assemble codeword (encode) or form syndrome and overall parity (decode)
  always_comb begin
    in_d      = bus.in_data[DATA_W-1:0];
    in_par    = calc_par(in_d);
    s1_syn_d  = '0;
    s1_ov_d   = 1'b0;
    s1_word_d = {^{in_par, in_d}, in_par, in_d};
    if (bus.in_mode) begin
      s1_word_d = bus.in_data;
      s1_syn_d  = in_par ^ bus.in_data[DATA_W +: PAR_W];
      s1_ov_d   = ^bus.in_data;
    end
  end

  logic              s1_valid;
  logic              s1_mode;
  logic [CW_W-1:0]   s1_word;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_ov;

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
      s1_ov    <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s1_mode  <= bus.in_mode;
      s1_word  <= s1_word_d;
      s1_syn   <= s1_syn_d;
      s1_ov    <= s1_ov_d;
    end
  end

  logic [CW_W-1:0] fix_word;
  logic            fix_single;
  logic            fix_double;

  // Stage 2 front end: classify the decode result and flip the single bad bit if correctable
  always_comb begin
    fix_word   = s1_word;
    fix_single = 1'b0;
    fix_double = 1'b0;
    if (s1_mode) begin
      if (s1_ov) begin
        if (s1_syn == '0) begin
          fix_word[CW_W-1] = ~s1_word[CW_W-1];
          fix_single       = 1'b1;
        end else if (int'(s1_syn) <= MAX_POS) begin
          for (int k = 0; k < DATA_W; k++) begin
            if (int'(s1_syn) == data_pos(k)) fix_word[k] = ~s1_word[k];
          end
          for (int i = 0; i < PAR_W; i++) begin
            if (int'(s1_syn) == (1 << i)) fix_word[DATA_W+i] = ~s1_word[DATA_W+i];
          end
          fix_single = 1'b1;
        end else begin
          fix_double = 1'b1;
        end
      end else if (s1_syn != '0) begin
        fix_double = 1'b1;
      end
    end
  end

  // Stage 2 register drives every output of the stream
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid      <= 1'b0;
      bus.out_mode       <= 1'b0;
      bus.out_data       <= '0;
      bus.out_syndrome   <= '0;
      bus.out_single_err <= 1'b0;
      bus.out_double_err <= 1'b0;
    end else if (adv) begin
      bus.out_valid      <= s1_valid;
      bus.out_mode       <= s1_mode;
      bus.out_data       <= fix_word;
      bus.out_syndrome   <= s1_syn;
      bus.out_single_err <= fix_single;
      bus.out_double_err <= fix_double;
    end
  end

  logic delivered;
  assign delivered = bus.out_valid && bus.out_ready && bus.out_mode;

  // Saturating error statistics, counted only when a decoded word actually leaves
  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      if (delivered && bus.out_single_err && (corr_count != {CNT_W{1'b1}}))
        corr_count <= corr_count + CNT_W'(1);
      if (delivered && bus.out_double_err && (uncorr_count != {CNT_W{1'b1}}))
        uncorr_count <= uncorr_count + CNT_W'(1);
    end
  end

endmodule
